// File: rtl/mat_vec_mul_stream_pkg.sv
// -----------------------------------------------------------------------------
// mat_vec_mul_stream_pkg
// Shared definitions for the streaming matrix-vector multiplier:
//   - FSM state encoding
//   - field constants (GF(2^8) polynomial 0x11B, prime modulus 251)
//   - FIELD parameter string constants
//   - per-byte field arithmetic helpers used by field_mac_lane
// No ports (package).
// -----------------------------------------------------------------------------
package mat_vec_mul_stream_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam logic [8:0] GF_POLY    = 9'h11B;
    localparam int         P251_MOD   = 251;

    localparam string      FIELD_P251  = "P251";
    localparam string      FIELD_GF256 = "GF256";

    // Bring an 8-bit operand into 0..250; a single subtraction suffices
    // because 2*251 > 255.
    function automatic logic [7:0] p251_reduce(input logic [7:0] a);
        return (a >= 8'(P251_MOD)) ? a - 8'(P251_MOD) : a;
    endfunction

    function automatic logic [7:0] p251_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(p251_reduce(a)) * 16'(p251_reduce(b));
        return 8'(p % 16'(P251_MOD));
    endfunction

    function automatic logic [7:0] p251_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, p251_reduce(a)} + {1'b0, p251_reduce(b)};
        return (s >= 9'(P251_MOD)) ? 8'(s - 9'(P251_MOD)) : s[7:0];
    endfunction

    // Shift-and-add multiply; each doubling of x is reduced by the field
    // polynomial so the running value never leaves 8 bits.
    function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x;
        logic [7:0] r;
        x = a;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x[7] ? ((x << 1) ^ GF_POLY[7:0]) : (x << 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/mat_vec_mul_stream_if.sv
// -----------------------------------------------------------------------------
// mat_vec_mul_stream_if
// Bundles every non-clock/reset signal of mat_vec_mul_stream.
//   control : i_start, i_accumulate, i_n_words, i_n_cols
//   matrix  : i_mat, i_mat_valid, o_mat_ready   (column-major beats)
//   vector  : o_vec_rd, o_vec_addr, i_vec        (i_vec one cycle after rd)
//   result  : i_res_en, i_res_addr, o_res        (1-cycle read latency)
//   status  : o_busy, o_done
// Signal names are from the multiplier's point of view; 'slave' is the
// multiplier side, 'master' the side that drives it.
// -----------------------------------------------------------------------------
interface mat_vec_mul_stream_if #(
    parameter int N_GF      = 4,
    parameter int MAX_WORDS = 64,
    parameter int MAX_COLS  = 512
);
    localparam int PROC_SIZE = 8 * N_GF;
    localparam int AW        = $clog2(MAX_WORDS);
    localparam int CW        = $clog2(MAX_COLS);

    logic                 i_start;
    logic                 i_accumulate;
    logic [AW:0]          i_n_words;
    logic [CW:0]          i_n_cols;
    logic [PROC_SIZE-1:0] i_mat;
    logic                 i_mat_valid;
    logic                 o_mat_ready;
    logic                 o_vec_rd;
    logic [CW-1:0]        o_vec_addr;
    logic [7:0]           i_vec;
    logic                 i_res_en;
    logic [AW-1:0]        i_res_addr;
    logic [PROC_SIZE-1:0] o_res;
    logic                 o_busy;
    logic                 o_done;

    modport slave (
        input  i_start, i_accumulate, i_n_words, i_n_cols,
        input  i_mat, i_mat_valid, i_vec, i_res_en, i_res_addr,
        output o_mat_ready, o_vec_rd, o_vec_addr, o_res, o_busy, o_done
    );

    modport master (
        output i_start, i_accumulate, i_n_words, i_n_cols,
        output i_mat, i_mat_valid, i_vec, i_res_en, i_res_addr,
        input  o_mat_ready, o_vec_rd, o_vec_addr, o_res, o_busy, o_done
    );

endinterface

// File: rtl/mat_vec_mul_stream_field_mac_lane.sv
// -----------------------------------------------------------------------------
// field_mac_lane
// One byte lane of the MAC: registered product, combinational accumulate.
//   i_clk  : clock
//   i_a    : matrix byte (pipeline stage 1 operand)
//   i_b    : vector byte (pipeline stage 1 operand)
//   i_acc  : previous result byte, aligned with the registered product
//   o_sum  : i_acc + registered product in the selected field
// -----------------------------------------------------------------------------
module field_mac_lane
    import mat_vec_mul_stream_pkg::*;
#(
    parameter string FIELD = FIELD_P251
) (
    input  logic       i_clk,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [7:0] i_acc,
    output logic [7:0] o_sum
);

    localparam bit IS_GF = (FIELD == FIELD_GF256);

    logic [7:0] prod_d;
    logic [7:0] prod_q;

    always_comb begin
        prod_d = IS_GF ? gf256_mul(i_a, i_b) : p251_mul(i_a, i_b);
    end

    // NOTE: pure datapath register -- validity is tracked by the parent's
    // reset valid bits, so this needs no reset; <= keeps it a flop.
    always_ff @(posedge i_clk) begin
        prod_q <= prod_d;
    end

    always_comb begin
        o_sum = IS_GF ? (i_acc ^ prod_q) : p251_add(i_acc, prod_q);
    end

endmodule

// File: rtl/mat_vec_mul_stream.sv
// -----------------------------------------------------------------------------
// mat_vec_mul_stream
// Streams a column-major matrix against a byte vector and accumulates
// R[w] (+)= sum_c M[c][w] * v[c] per byte lane into an on-chip result RAM.
//   i_clk : clock
//   i_rst : synchronous active-high reset
//   bus   : mat_vec_mul_stream_if.slave (control, matrix stream, vector
//           read, result read, status)
// Pipeline: stage 0 accept + RAM read, stage 1 product register,
// stage 2 add + write-back. In-flight results are forwarded to stage 1 so
// back-to-back updates of the same word (n_words = 1) stay correct.
// -----------------------------------------------------------------------------
module mat_vec_mul_stream
    import mat_vec_mul_stream_pkg::*;
#(
    parameter string FIELD     = FIELD_P251,
    parameter int    N_GF      = 4,
    parameter int    MAX_WORDS = 64,
    parameter int    MAX_COLS  = 512
) (
    input logic                 i_clk,
    input logic                 i_rst,
    mat_vec_mul_stream_if.slave bus
);

    localparam int PROC_SIZE = 8 * N_GF;
    localparam int AW        = $clog2(MAX_WORDS);
    localparam int CW        = $clog2(MAX_COLS);

    // ---------------- control state ----------------
    state_t        state_q, state_d;
    logic [AW-1:0] word_q, word_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW:0]   n_words_q, n_words_d;
    logic [CW:0]   n_cols_q, n_cols_d;
    logic          done_q, done_d;
    logic          vec_pend_q;

    logic [AW:0]   n_words_clamp;
    logic [CW:0]   n_cols_clamp;
    logic          accept;
    logic          last_word;
    logic          last_col;
    logic          clr_we;

    // ---------------- datapath ----------------
    logic                 s1_valid_q, s2_valid_q, wb_valid_q;
    logic [AW-1:0]        s1_addr_q, s2_addr_q, wb_addr_q;
    logic [PROC_SIZE-1:0] s1_mat_q;
    logic [7:0]           s1_vec_q;
    logic [PROC_SIZE-1:0] s2_old_q;
    logic [PROC_SIZE-1:0] wb_data_q;
    logic [PROC_SIZE-1:0] sum;
    logic [PROC_SIZE-1:0] fwd_old;
    logic [7:0]           vec_q;
    logic [7:0]           vec_cur;

    logic [PROC_SIZE-1:0] mem_q [MAX_WORDS];
    logic [PROC_SIZE-1:0] rd_data_q;
    logic                 mem_we, mem_re;
    logic [AW-1:0]        mem_wa, mem_ra;
    logic [PROC_SIZE-1:0] mem_wd;

    assign n_words_clamp = (bus.i_n_words > (AW+1)'(MAX_WORDS)) ? (AW+1)'(MAX_WORDS) : bus.i_n_words;
    assign n_cols_clamp  = (bus.i_n_cols  > (CW+1)'(MAX_COLS))  ? (CW+1)'(MAX_COLS)  : bus.i_n_cols;

    assign accept    = (state_q == RUN) && bus.i_mat_valid;
    assign last_word = ({1'b0, word_q} == n_words_q - (AW+1)'(1));
    assign last_col  = ({1'b0, col_q}  == n_cols_q  - (CW+1)'(1));

    // The vector byte arrives the cycle after FETCH, which is also the first
    // RUN cycle, so use it straight from the port until it is registered.
    assign vec_cur = vec_pend_q ? bus.i_vec : vec_q;

    // ---------------- FSM: next state ----------------
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves a signal unassigned (no latches).
        state_d   = state_q;
        word_d    = word_q;
        col_d     = col_q;
        n_words_d = n_words_q;
        n_cols_d  = n_cols_q;
        done_d    = 1'b0;
        clr_we    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    n_words_d = n_words_clamp;
                    n_cols_d  = n_cols_clamp;
                    word_d    = '0;
                    col_d     = '0;
                    if ((n_words_clamp == '0) || (n_cols_clamp == '0)) begin
                        done_d = 1'b1;
                    end else if (bus.i_accumulate) begin
                        state_d = FETCH;
                    end else begin
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                clr_we = 1'b1;
                if (last_word) begin
                    word_d  = '0;
                    state_d = FETCH;
                end else begin
                    word_d = word_q + 1'b1;
                end
            end
            FETCH: begin
                state_d = RUN;
            end
            RUN: begin
                if (accept) begin
                    if (last_word) begin
                        word_d = '0;
                        if (last_col) begin
                            state_d = DRAIN;
                        end else begin
                            col_d   = col_q + 1'b1;
                            state_d = FETCH;
                        end
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // The final beat leaves stage 1 after one DRAIN cycle; the
                // next cycle is its write-back, after which we are idle.
                if (!s1_valid_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- control registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            word_q     <= '0;
            col_q      <= '0;
            n_words_q  <= '0;
            n_cols_q   <= '0;
            done_q     <= 1'b0;
            vec_pend_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            col_q      <= col_d;
            n_words_q  <= n_words_d;
            n_cols_q   <= n_cols_d;
            done_q     <= done_d;
            vec_pend_q <= (state_q == FETCH);
            s1_valid_q <= accept;
            s2_valid_q <= s1_valid_q;
            wb_valid_q <= s2_valid_q;
        end
    end

    // ---------------- pipeline data ----------------
    // Stage 1 picks the freshest copy of its word: the stage-2 sum being
    // written this cycle, else the word written last cycle (the RAM read
    // returned the pre-write value), else the RAM read data.
    always_comb begin
        fwd_old = rd_data_q;
        if (s2_valid_q && (s2_addr_q == s1_addr_q)) begin
            fwd_old = sum;
        end else if (wb_valid_q && (wb_addr_q == s1_addr_q)) begin
            fwd_old = wb_data_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            s1_addr_q <= word_q;
            s1_mat_q  <= bus.i_mat;
            s1_vec_q  <= vec_cur;
        end
        if (s1_valid_q) begin
            s2_addr_q <= s1_addr_q;
            s2_old_q  <= fwd_old;
        end
        if (s2_valid_q) begin
            wb_addr_q <= s2_addr_q;
            wb_data_q <= sum;
        end
        if (vec_pend_q) begin
            vec_q <= bus.i_vec;
        end
    end

    for (genvar g = 0; g < N_GF; g++) begin : g_lane
        field_mac_lane #(
            .FIELD (FIELD)
        ) u_lane (
            .i_clk (i_clk),
            .i_a   (s1_mat_q[8*g +: 8]),
            .i_b   (s1_vec_q),
            .i_acc (s2_old_q[8*g +: 8]),
            .o_sum (sum[8*g +: 8])
        );
    end

    // ---------------- result RAM ----------------
    // Port A: clear / write-back (gated by reset so an abort writes nothing).
    // Port B: pipeline read while busy, result port while idle.
    assign mem_we = !i_rst && (clr_we || s2_valid_q);
    assign mem_wa = clr_we ? word_q : s2_addr_q;
    assign mem_wd = clr_we ? '0 : sum;
    assign mem_re = accept || ((state_q == IDLE) && bus.i_res_en);
    assign mem_ra = accept ? word_q : bus.i_res_addr;

    // NOTE: the RAM array has no reset; its contents are defined only by
    // CLEAR or write-back, which lets it map onto block RAM.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
        if (mem_re) begin
            rd_data_q <= mem_q[mem_ra];
        end
    end

    // ---------------- outputs ----------------
    assign bus.o_mat_ready = (state_q == RUN);
    assign bus.o_vec_rd    = (state_q == FETCH);
    assign bus.o_vec_addr  = col_q;
    assign bus.o_busy      = (state_q != IDLE);
    assign bus.o_done      = done_q;
    assign bus.o_res       = rd_data_q;

endmodule

// File: tb/tb_mat_vec_mul_stream.sv
// -----------------------------------------------------------------------------
// tb_mat_vec_mul_stream
// Drives a P251 and a GF256 instance with identical stimulus and compares
// their result memories against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mat_vec_mul_stream;

    localparam int NG = 4;
    localparam int MW = 64;
    localparam int MC = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // shared stimulus
    logic        start     = 1'b0;
    logic        accum     = 1'b0;
    logic [6:0]  n_words   = '0;
    logic [9:0]  n_cols    = '0;
    logic [31:0] mat       = '0;
    logic        mat_valid = 1'b0;
    logic [7:0]  vec       = '0;
    logic        res_en    = 1'b0;
    logic [5:0]  res_addr  = '0;

    mat_vec_mul_stream_if #(.N_GF(NG), .MAX_WORDS(MW), .MAX_COLS(MC)) bus_p ();
    mat_vec_mul_stream_if #(.N_GF(NG), .MAX_WORDS(MW), .MAX_COLS(MC)) bus_g ();

    assign bus_p.i_start = start;      assign bus_g.i_start = start;
    assign bus_p.i_accumulate = accum; assign bus_g.i_accumulate = accum;
    assign bus_p.i_n_words = n_words;  assign bus_g.i_n_words = n_words;
    assign bus_p.i_n_cols = n_cols;    assign bus_g.i_n_cols = n_cols;
    assign bus_p.i_mat = mat;          assign bus_g.i_mat = mat;
    assign bus_p.i_mat_valid = mat_valid; assign bus_g.i_mat_valid = mat_valid;
    assign bus_p.i_vec = vec;          assign bus_g.i_vec = vec;
    assign bus_p.i_res_en = res_en;    assign bus_g.i_res_en = res_en;
    assign bus_p.i_res_addr = res_addr; assign bus_g.i_res_addr = res_addr;

    mat_vec_mul_stream #(.FIELD("P251"), .N_GF(NG), .MAX_WORDS(MW), .MAX_COLS(MC)) dut_p (
        .i_clk (clk), .i_rst (rst), .bus (bus_p));
    mat_vec_mul_stream #(.FIELD("GF256"), .N_GF(NG), .MAX_WORDS(MW), .MAX_COLS(MC)) dut_g (
        .i_clk (clk), .i_rst (rst), .bus (bus_g));

    // reference data
    logic [7:0]  vec_mem [MC];
    logic [31:0] beats [$];
    logic [31:0] exp_p [MW];
    logic [31:0] exp_g [MW];

    int n_err = 0;
    int n_chk = 0;
    int vec_rd_cnt = 0;

    // Vector source: answers a read exactly one cycle later, junk otherwise.
    logic       vpend = 1'b0;
    logic [8:0] vaddr = '0;
    always @(negedge clk) begin
        if (vpend) vec = vec_mem[vaddr];
        else       vec = 8'($urandom);
        vpend = bus_p.o_vec_rd;
        vaddr = bus_p.o_vec_addr;
        if (bus_p.o_vec_rd) vec_rd_cnt = vec_rd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int gmul(input int a, input int b);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
        for (int k = 14; k >= 8; k--) if (((p >> k) & 1) != 0) p = p ^ ('h11B << (k - 8));
        return p;
    endfunction

    task automatic model_run(input bit acc, input int nw, input int nc);
        int we, ce, rp, rg, a, b;
        logic [31:0] m;
        we = (nw > MW) ? MW : nw;
        ce = (nc > MC) ? MC : nc;
        if (we == 0 || ce == 0) return;
        for (int w = 0; w < we; w++) begin
            for (int l = 0; l < NG; l++) begin
                rp = acc ? int'(exp_p[w][8*l +: 8]) : 0;
                rg = acc ? int'(exp_g[w][8*l +: 8]) : 0;
                for (int c = 0; c < ce; c++) begin
                    m  = beats[c*we + w];
                    a  = int'(m[8*l +: 8]);
                    b  = int'(vec_mem[c]);
                    rp = (rp + (a % 251) * (b % 251)) % 251;
                    rg = rg ^ gmul(a, b);
                end
                exp_p[w][8*l +: 8] = 8'(rp);
                exp_g[w][8*l +: 8] = 8'(rg);
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic fill_random(input int nw, input int nc);
        beats.delete();
        for (int i = 0; i < nw*nc; i++) beats.push_back($urandom);
        for (int c = 0; c < nc; c++) vec_mem[c] = 8'($urandom);
    endtask

    task automatic do_start(input bit acc, input int nw, input int nc);
        accum   = acc;
        n_words = 7'(nw);
        n_cols  = 10'(nc);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Offers beats at negedges; a beat counts as taken when valid and ready
    // are both high going into the next posedge.
    task automatic feed(input int gap, input int limit, output int last_acc, output int n_acc);
        int guard;
        n_acc = 0; last_acc = 0; guard = 0;
        while (n_acc < limit && guard < 4000) begin
            if (int'($urandom_range(99)) < gap) begin
                mat_valid = 1'b0;
                mat = $urandom;
            end else begin
                mat_valid = 1'b1;
                mat = beats[n_acc];
            end
            if (mat_valid && bus_p.o_mat_ready) begin
                n_acc++;
                last_acc = cyc;
            end
            @(negedge clk);
            guard++;
        end
        mat_valid = 1'b0;
        if (guard >= 4000) check("feed_timeout", 32'(n_acc), 32'(limit));
    endtask

    task automatic wait_done(input string tag, input int last_acc);
        int lat;
        lat = -1;
        check({tag, "_ready_after_last"}, 32'(bus_p.o_mat_ready), 32'd0);
        for (int i = 0; i < 20; i++) begin
            if (bus_p.o_done) begin
                lat = cyc - last_acc;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done_latency"}, 32'(lat), 32'd3);
        check({tag, "_busy_at_done"}, 32'(bus_p.o_busy), 32'd0);
        check({tag, "_g_done"}, 32'(bus_g.o_done), 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus_p.o_done), 32'd0);
    endtask

    task automatic read_word(input int w, output logic [31:0] rp, output logic [31:0] rg);
        res_en   = 1'b1;
        res_addr = 6'(w);
        @(negedge clk);
        res_en   = 1'b0;
        rp = bus_p.o_res;
        rg = bus_g.o_res;
    endtask

    task automatic check_words(input string tag, input int nw);
        logic [31:0] rp, rg;
        for (int w = 0; w < nw; w++) begin
            read_word(w, rp, rg);
            check($sformatf("%s_p[%0d]", tag, w), rp, exp_p[w]);
            check($sformatf("%s_g[%0d]", tag, w), rg, exp_g[w]);
        end
    endtask

    task automatic run_op(input string tag, input bit acc, input int nw, input int nc, input int gap);
        int last_acc, n_acc, nbeats;
        nbeats = ((nw > MW) ? MW : nw) * nc;
        do_start(acc, nw, nc);
        feed(gap, nbeats, last_acc, n_acc);
        check({tag, "_beats"}, 32'(n_acc), 32'(nbeats));
        wait_done(tag, last_acc);
        model_run(acc, nw, nc);
        check_words(tag, (nw > MW) ? MW : nw);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rp, rg;
        int last_acc, n_acc, rd_before;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy",     32'(bus_p.o_busy),      32'd0);
        check("rst_done",     32'(bus_p.o_done),      32'd0);
        check("rst_ready",    32'(bus_p.o_mat_ready), 32'd0);
        check("rst_vec_rd",   32'(bus_p.o_vec_rd),    32'd0);
        check("rst_vec_addr", 32'(bus_p.o_vec_addr),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // all-250 matrix and vector: each byte 3, then 6 when accumulated
        beats.delete();
        for (int i = 0; i < 6; i++) beats.push_back(32'hFAFA_FAFA);
        for (int c = 0; c < 3; c++) vec_mem[c] = 8'd250;
        run_op("p250", 1'b0, 2, 3, 0);
        read_word(1, rp, rg);
        check("p250_const", rp, 32'h0303_0303);
        run_op("p250_acc", 1'b1, 2, 3, 0);
        read_word(0, rp, rg);
        check("p250_acc_const", rp, 32'h0606_0606);

        // random data with ~50% valid gaps
        fill_random(3, 4);
        run_op("gaps", 1'b0, 3, 4, 50);

        // single-word columns: 0x57 * {0x83, 0x01} in GF(2^8)
        beats.delete();
        beats.push_back(32'h5757_5757);
        beats.push_back(32'h5757_5757);
        vec_mem[0] = 8'h83;
        vec_mem[1] = 8'h01;
        run_op("gf57", 1'b0, 1, 2, 0);
        read_word(0, rp, rg);
        check("gf57_const", rg, 32'h9696_9696);

        // forwarding under stalls, then accumulate on the same word
        fill_random(1, 5);
        run_op("fwd", 1'b0, 1, 5, 30);
        fill_random(1, 3);
        run_op("fwd_acc", 1'b1, 1, 3, 0);

        // zero-length run: immediate done, no vector reads, memory untouched
        fill_random(3, 4);
        run_op("pre_zero", 1'b0, 3, 4, 20);
        rd_before = vec_rd_cnt;
        do_start(1'b0, 3, 0);
        check("zero_done", 32'(bus_p.o_done), 32'd1);
        check("zero_busy", 32'(bus_p.o_busy), 32'd0);
        @(negedge clk);
        check("zero_done_pulse", 32'(bus_p.o_done), 32'd0);
        do_start(1'b1, 0, 4);
        check("zero_w_done", 32'(bus_p.o_done), 32'd1);
        @(negedge clk);
        check("zero_vec_rd", 32'(vec_rd_cnt), 32'(rd_before));
        check_words("zero_mem", 3);

        // oversized word count is clamped to the RAM depth
        fill_random(MW, 1);
        run_op("clamp", 1'b0, 100, 1, 0);

        // abort mid-run, then a clean run
        fill_random(3, 4);
        do_start(1'b0, 3, 4);
        feed(0, 5, last_acc, n_acc);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy",   32'(bus_p.o_busy),      32'd0);
        check("abort_done",   32'(bus_p.o_done),      32'd0);
        check("abort_ready",  32'(bus_p.o_mat_ready), 32'd0);
        check("abort_vec_rd", 32'(bus_p.o_vec_rd),    32'd0);
        rst = 1'b0;
        @(negedge clk);
        fill_random(3, 4);
        run_op("after_abort", 1'b0, 3, 4, 25);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mat_vec_mul_stream.md
MAT_VEC_MUL_STREAM -- requirements
Module: mat_vec_mul_stream

Interface
REQ-001 SHALL have parameter FIELD, default "P251", arithmetic field; legal values "P251" and "GF256".
REQ-002 SHALL have parameter N_GF, default 4, number of byte lanes per matrix word; PROC_SIZE = 8*N_GF.
REQ-003 SHALL have parameter MAX_WORDS, default 64, result-memory depth in PROC_SIZE words.
REQ-004 SHALL have parameter MAX_COLS, default 512, maximum vector length in bytes.
REQ-005 SHALL have ports i_clk (in, 1, clock) and i_rst (in, 1, reset); reset i_rst is synchronous, active-high; clock i_clk.
REQ-006 SHALL have ports i_start (in, 1, start pulse) and i_accumulate (in, 1, sampled at start; 1 skips result clear).
REQ-007 SHALL have ports i_n_words (in, clog2(MAX_WORDS)+1, words per matrix column) and i_n_cols (in, clog2(MAX_COLS)+1, vector length); both are sampled at start.
REQ-008 SHALL have matrix stream ports i_mat (in, PROC_SIZE), i_mat_valid (in, 1) and o_mat_ready (out, 1); beats arrive in column-major order.
REQ-009 SHALL have vector port o_vec_rd (out, 1), o_vec_addr (out, clog2(MAX_COLS), byte index) and i_vec (in, 8); i_vec is valid one cycle after o_vec_rd.
REQ-010 SHALL have result read port i_res_en (in, 1), i_res_addr (in, clog2(MAX_WORDS)) and o_res (out, PROC_SIZE), with 1-cycle read latency.
REQ-011 SHALL have status outputs o_busy (out, 1) and o_done (out, 1, single-cycle pulse).

Function
REQ-012 SHALL compute R[w] = R0[w] + sum over c of M[c][w]*v[c], lane-wise per byte, where R0 = 0 if i_accumulate=0 and R0 = prior memory contents otherwise.
REQ-013 In P251 mode, multiply and add SHALL be modulo 251; operands 251..255 are reduced mod 251 first; results are always <251.
REQ-014 In GF256 mode, add SHALL be XOR and multiply SHALL be modulo x^8+x^4+x^3+x+1 (0x11B).
REQ-015 The block SHALL have the states IDLE, CLEAR, FETCH, RUN and DRAIN.
REQ-016 IDLE: i_start=1 SHALL go to CLEAR if i_accumulate=0, otherwise to FETCH; i_start while o_busy=1 SHALL be ignored.
REQ-017 CLEAR SHALL write zero to words 0..n_words-1, one word per cycle, then go to FETCH.
REQ-018 FETCH SHALL assert o_vec_rd for one cycle with o_vec_addr = current column, then go to RUN; o_mat_ready=0 during FETCH.
REQ-019 RUN SHALL assert o_mat_ready=1 and accept a beat on valid&ready; the word counter SHALL wrap at n_words-1, advancing the column and returning to FETCH; after the final beat the block SHALL go to DRAIN.
REQ-020 i_mat_valid=0 in RUN SHALL stall with no state change; no beat is lost or duplicated.
REQ-021 The MAC pipeline SHALL be: accept plus memory read (stage 0), registered product (stage 1), add plus write-back (stage 2).
REQ-022 The block SHALL forward in-flight write data so that back-to-back updates of the same word are correct, including the n_words=1 case.
REQ-023 o_done SHALL pulse exactly 3 cycles after acceptance of the final beat; o_busy SHALL fall in the same cycle and the state SHALL return to IDLE.
REQ-024 If i_n_words=0 or i_n_cols=0, the block SHALL skip CLEAR/FETCH/RUN, leave memory unchanged, and pulse o_done 1 cycle after start.
REQ-025 i_n_words > MAX_WORDS or i_n_cols > MAX_COLS SHALL be clamped to the maximum.
REQ-026 o_busy SHALL be 1 in every state except IDLE.
REQ-027 Result reads SHALL be honoured only in IDLE; o_res is undefined while busy.

Reset
REQ-028 Reset SHALL return the FSM to IDLE and drive o_mat_ready, o_vec_rd, o_busy and o_done to 0 and o_vec_addr to 0.
REQ-029 Reset mid-operation SHALL abort immediately, with no further memory writes from the pipeline; memory contents are then undefined.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the field polynomial 0x11B, the modulus 251, and the FIELD string constants.
REQ-031 The per-lane multiply/add SHALL be one sub-module, field_mac_lane (FIELD parameter, registered product, combinational add), instantiated N_GF times.
REQ-032 The result memory SHALL be a dual-port RAM: one port for RMW write-back/clear, one for reads and the result port.

Verification
REQ-033 P251, N_GF=4, n_words=2, n_cols=3, M all 250, v all 250 -> every byte = 3*(250*250 mod 251) mod 251 = 3; o_done 3 cycles after last beat.
REQ-034 GF256, n_words=1, n_cols=2, M bytes 0x57, v = {0x83, 0x01} -> every byte = 0xC1 ^ 0x57 = 0x96; forwarding exercised.
REQ-035 Accumulate: run REQ-033 twice, second run with i_accumulate=1 -> every byte = 6.
REQ-036 Random i_mat_valid gaps (50%), n_words=3, n_cols=4 -> results match the golden model, with exactly 12 beats accepted.
REQ-037 Assert i_rst during RUN, then start a fresh run with i_accumulate=0 -> o_done/o_busy reset to 0 and the second run's result is correct.
REQ-038 i_n_cols=0 -> o_done pulses 1 cycle after i_start, memory unchanged, and o_vec_rd is never asserted.
